path_neighbor_gen: RTL and testbench

Sequential grid-neighbour generator for the path-search datapath. It accepts a linear node index and the grid dimensions. It derives row and column with an iterative divider, so no combinational divide/modulo is used. It then streams every in-bounds neighbour index, one per handshake, in fixed direction order. It sits between the priority-queue pop stage and the cost-update stage, and supports 4- or 8-connectivity.

---
 rtl/path_neighbor_gen.sv | 208 ++++++++++++++++++++
 tb/tb_path_neighbor_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/path_neighbor_gen.sv
// Grid neighbour generator: an iterative divider finds row/col,
// then in-bounds neighbour indices stream out one per handshake.
module path_neighbor_gen #(
  parameter int W    = 16,
  parameter int CONN = 4,
  parameter int DW   = 3
) (
  input  logic          system1000,
  input  logic          system1000_rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [W-1:0]  req_node,
  input  logic [W-1:0]  grid_w,
  input  logic [W-1:0]  grid_h,
  output logic          nb_valid,
  input  logic          nb_ready,
  output logic [W-1:0]  nb_node,
  output logic [DW-1:0] nb_dir,
  output logic          nb_last,
  output logic          done,
  output logic          err
);

  localparam int CW = $clog2(W);

  if (CONN != 4 && CONN != 8) begin : gBadConn
    $error("CONN must be 4 or 8");
  end

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    EMIT,
    DONE
  } stateT;

  stateT state;
  stateT stateN;

  logic            liveQ;
  logic            errQ;
  logic [W-1:0]    nodeQ;
  logic [W-1:0]    gridWQ;
  logic [W-1:0]    gridHQ;
  logic [W-1:0]    quoQ;
  logic [W-1:0]    remQ;
  logic [CW-1:0]   cntQ;
  logic [CONN-1:0] validQ;
  logic [DW-1:0]   ptrQ;

  // One restoring-division step: shift in the next dividend bit.
  logic [W:0]   remSh;
  logic         fits;
  logic [W-1:0] remNext;
  logic [W-1:0] quoNext;

  assign remSh   = {remQ, quoQ[W-1]};
  assign fits    = remSh >= {1'b0, gridWQ};
  assign remNext = fits ? W'(remSh - {1'b0, gridWQ})
                        : remSh[W-1:0];
  assign quoNext = {quoQ[W-2:0], fits};

  // Bounds are evaluated at W+1 bits so full-range grids cannot wrap.
  logic dnOk;
  logic rtOk;
  logic upOk;
  logic lfOk;
  logic badReq;
  logic divLast;

  assign dnOk = ({1'b0, quoNext} + (W+1)'(1))
              < {1'b0, gridHQ};
  assign rtOk = ({1'b0, remNext} + (W+1)'(1))
              < {1'b0, gridWQ};
  assign upOk = |quoNext;
  assign lfOk = |remNext;

  assign badReq  = (gridWQ == '0) || (quoNext >= gridHQ);
  assign divLast = (state == DIV) && (cntQ == CW'(W - 1));

  logic [CONN-1:0] vRaw;
  logic [CONN-1:0] vNew;

  if (CONN == 8) begin : gConn8
    assign vRaw = {upOk & lfOk, upOk & rtOk,
                   dnOk & lfOk, dnOk & rtOk,
                   lfOk, upOk, rtOk, dnOk};
  end else begin : gConn4
    assign vRaw = {lfOk, upOk, rtOk, dnOk};
  end

  assign vNew = badReq ? '0 : vRaw;

  function automatic logic [DW-1:0] lowIdx(
    input logic [CONN-1:0] v
  );
    lowIdx = '0;
    for (int i = CONN - 1; i >= 0; i--)
      if (v[i]) lowIdx = DW'(i);
  endfunction

  logic [CONN-1:0] higher;
  logic            lastItem;

  always_comb begin
    higher = '0;
    for (int i = 0; i < CONN; i++)
      higher[i] = validQ[i] && (DW'(i) > ptrQ);
  end

  assign lastItem = ~|higher;

  always_comb begin
    stateN = state;
    unique case (1'b1)
      (state == IDLE):
        if (req_valid && liveQ) stateN = DIV;
      (state == DIV):
        if (divLast)
          stateN = (vNew == '0) ? DONE : EMIT;
      (state == EMIT):
        if (nb_ready && lastItem) stateN = DONE;
      default:
        stateN = IDLE;
    endcase
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      state <= IDLE;
      liveQ <= 1'b0;
    end else begin
      state <= stateN;
      liveQ <= 1'b1;
    end
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      errQ   <= 1'b0;
      nodeQ  <= '0;
      gridWQ <= '0;
      gridHQ <= '0;
      quoQ   <= '0;
      remQ   <= '0;
      cntQ   <= '0;
      validQ <= '0;
      ptrQ   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid && liveQ) begin
            nodeQ  <= req_node;
            gridWQ <= grid_w;
            gridHQ <= grid_h;
            quoQ   <= req_node;
            remQ   <= '0;
            cntQ   <= '0;
          end
        end
        DIV: begin
          quoQ <= quoNext;
          remQ <= remNext;
          cntQ <= cntQ + CW'(1);
          if (divLast) begin
            validQ <= vNew;
            errQ   <= badReq;
            ptrQ   <= lowIdx(vNew);
          end
        end
        EMIT: begin
          if (nb_ready && !lastItem)
            ptrQ <= lowIdx(higher);
        end
        default: ;
      endcase
    end
  end

  logic [W-1:0] cand;

  always_comb begin
    cand = '0;
    case (ptrQ)
      DW'(0): cand = nodeQ + gridWQ;
      DW'(1): cand = nodeQ + W'(1);
      DW'(2): cand = nodeQ - gridWQ;
      DW'(3): cand = nodeQ - W'(1);
      DW'(4): cand = nodeQ + gridWQ + W'(1);
      DW'(5): cand = nodeQ + gridWQ - W'(1);
      DW'(6): cand = nodeQ - gridWQ + W'(1);
      DW'(7): cand = nodeQ - gridWQ - W'(1);
      default: cand = '0;
    endcase
  end

  logic emitOn;
  assign emitOn = (state == EMIT);

  assign req_ready = liveQ && (state == IDLE);
  assign nb_valid  = emitOn;
  assign nb_node   = emitOn ? cand : '0;
  assign nb_dir    = emitOn ? ptrQ : '0;
  assign nb_last   = emitOn && lastItem;
  assign done      = (state == DONE);
  assign err       = (state == DONE) && errQ;

endmodule

// File: tb/tb_path_neighbor_gen.sv
// Bench for path_neighbor_gen: CONN=4 and CONN=8 instances share
// requests; a geometric neighbour model supplies expected streams.
module tb_path_neighbor_gen;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         reqValid = 1'b0;
  logic [W-1:0] reqNode = '0;
  logic [W-1:0] gridW = '0;
  logic [W-1:0] gridH = '0;

  logic         rr4, nv4, nl4, dn4, er4;
  logic         nr4 = 1'b0;
  logic [W-1:0] nn4;
  logic [2:0]   nd4;
  logic         rr8, nv8, nl8, dn8, er8;
  logic         nr8 = 1'b0;
  logic [W-1:0] nn8;
  logic [2:0]   nd8;

  path_neighbor_gen #(.W(W), .CONN(4), .DW(3)) u4 (
    .system1000(clk), .system1000_rst(rst),
    .req_valid(reqValid), .req_ready(rr4),
    .req_node(reqNode), .grid_w(gridW), .grid_h(gridH),
    .nb_valid(nv4), .nb_ready(nr4), .nb_node(nn4),
    .nb_dir(nd4), .nb_last(nl4), .done(dn4), .err(er4)
  );

  path_neighbor_gen #(.W(W), .CONN(8), .DW(3)) u8 (
    .system1000(clk), .system1000_rst(rst),
    .req_valid(reqValid), .req_ready(rr8),
    .req_node(reqNode), .grid_w(gridW), .grid_h(gridH),
    .nb_valid(nv8), .nb_ready(nr8), .nb_node(nn8),
    .nb_dir(nd8), .nb_last(nl8), .done(dn8), .err(er8)
  );

  int nCmp = 0;
  int nBad = 0;

  int   exN[2][8];
  int   exD[2][8];
  int   exCnt[2];
  bit   exErr[2];
  int   idx[2];
  int   stall[2];
  int   lastHs[2];
  int   doneK[2];
  bit   held[2];
  bit   seen[2];
  logic [W-1:0] hN[2];
  logic [2:0]   hD[2];
  logic         hL[2];
  logic         nrDec[2];
  bit   bpOn;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s: observed %0d, expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Neighbours are the in-grid cells at fixed (drow,dcol) offsets.
  task automatic model(input int node, input int w, input int h);
    int dr[8];
    int dc[8];
    int row;
    int col;
    bit bad;
    dr = '{1, 0, -1, 0, 1, 1, -1, -1};
    dc = '{0, 1, 0, -1, 1, -1, 1, -1};
    row = 0;
    col = 0;
    bad = (w == 0);
    if (!bad) begin
      row = node / w;
      col = node % w;
      bad = (row >= h);
    end
    for (int c = 0; c < 2; c++) begin
      exErr[c] = bad;
      exCnt[c] = 0;
      if (!bad)
        for (int d = 0; d < (c ? 8 : 4); d++) begin
          int r2;
          int c2;
          r2 = row + dr[d];
          c2 = col + dc[d];
          if (r2 >= 0 && r2 < h && c2 >= 0 && c2 < w) begin
            exN[c][exCnt[c]] = (node + dr[d] * w + dc[d]) & 32'hFFFF;
            exD[c][exCnt[c]] = d;
            exCnt[c]++;
          end
        end
    end
  endtask

  task automatic mon(input int c, input int k, input logic rr,
                     input logic nv, input logic [W-1:0] nn,
                     input logic [2:0] nd, input logic nl,
                     input logic dn, input logic er);
    logic  go;
    string s;
    go = 1'b0;
    s = (c == 0) ? "c4" : "c8";
    if (held[c])
      chk({s, "_hold"}, {nv, nn, nd, nl}, {1'b1, hN[c], hD[c], hL[c]});
    if (nv) begin
      if (!seen[c]) begin
        chk({s, "_first_valid_cycle"}, k, W + 1);
        seen[c] = 1'b1;
      end
      if (!held[c]) stall[c] = bpOn ? 5 : 0;
      go = (stall[c] == 0);
      if (!go) stall[c]--;
      if (go) begin
        if (idx[c] < exCnt[c]) begin
          chk({s, "_node"}, nn, exN[c][idx[c]]);
          chk({s, "_dir"}, nd, exD[c][idx[c]]);
          chk({s, "_last"}, nl, idx[c] == exCnt[c] - 1);
          if (!bpOn)
            chk({s, "_item_cycle"}, k, W + 1 + idx[c]);
        end else begin
          chk({s, "_extra_item"}, idx[c], exCnt[c]);
        end
        idx[c]++;
        lastHs[c] = k;
      end
      held[c] = !go;
      hN[c] = nn;
      hD[c] = nd;
      hL[c] = nl;
    end else begin
      held[c] = 1'b0;
    end
    if (er) chk({s, "_err_with_done"}, dn, 1);
    if (dn) begin
      chk({s, "_err"}, er, exErr[c]);
      chk({s, "_item_count"}, idx[c], exCnt[c]);
      chk({s, "_done_cycle"}, k,
          (exCnt[c] == 0) ? W + 1 : lastHs[c] + 1);
      doneK[c] = k;
    end
    if (doneK[c] >= 0 && k == doneK[c] + 1)
      chk({s, "_ready_after_done"}, rr, 1);
    nrDec[c] = go;
  endtask

  task automatic runReq(input int node, input int w,
                        input int h, input bit bp);
    model(node, w, h);
    bpOn = bp;
    for (int c = 0; c < 2; c++) begin
      idx[c] = 0;
      stall[c] = 0;
      held[c] = 1'b0;
      seen[c] = 1'b0;
      lastHs[c] = -1;
      doneK[c] = -1;
    end
    chk("req_ready_idle", {rr4, rr8}, 2'b11);
    reqValid = 1'b1;
    reqNode = W'(node);
    gridW = W'(w);
    gridH = W'(h);
    step();
    reqValid = 1'b0;
    nr4 = 1'b0;
    nr8 = 1'b0;
    chk("req_ready_busy", {rr4, rr8}, 2'b00);
    for (int k = 1; k < 600; k++) begin
      mon(0, k, rr4, nv4, nn4, nd4, nl4, dn4, er4);
      mon(1, k, rr8, nv8, nn8, nd8, nl8, dn8, er8);
      nr4 = nrDec[0];
      nr8 = nrDec[1];
      if (doneK[0] >= 0 && doneK[1] >= 0 &&
          k > doneK[0] && k > doneK[1]) break;
      step();
    end
    chk("completed_in_budget", doneK[0] >= 0 && doneK[1] >= 0, 1);
  endtask

  initial begin
    step();
    step();
    chk("reset_c4", {rr4, nv4, nl4, dn4, er4, nn4, nd4}, 0);
    chk("reset_c8", {rr8, nv8, nl8, dn8, er8, nn8, nd8}, 0);
    rst = 1'b0;
    step();
    chk("ready_after_reset", {rr4, rr8}, 2'b11);

    runReq(5, 4, 3, 0);
    runReq(0, 4, 3, 0);
    runReq(11, 4, 3, 0);
    runReq(0, 1, 1, 0);
    runReq(7, 0, 3, 0);
    runReq(12, 4, 3, 0);
    runReq(5, 4, 3, 1);
    runReq(65534, 65535, 2, 0);
    runReq(65534, 1, 65535, 0);

    // Reset while the second neighbour is on the output.
    reqValid = 1'b1;
    reqNode = 16'd5;
    gridW = 16'd4;
    gridH = 16'd3;
    step();
    reqValid = 1'b0;
    nr4 = 1'b1;
    nr8 = 1'b1;
    repeat (W + 1) step();
    chk("second_item_pre_reset", {nv4, nn4, nd4}, {1'b1, 16'd6, 3'd1});
    rst = 1'b1;
    step();
    chk("midreset_c4", {rr4, nv4, nl4, dn4, er4, nn4, nd4}, 0);
    chk("midreset_c8", {rr8, nv8, nl8, dn8, er8, nn8, nd8}, 0);
    rst = 1'b0;
    nr4 = 1'b0;
    nr8 = 1'b0;
    step();
    runReq(0, 4, 3, 0);

    for (int t = 0; t < 24; t++) begin
      int w;
      int h;
      int n;
      w = $urandom_range(0, 7);
      h = $urandom_range(1, 7);
      n = $urandom_range(0, w * h + 3);
      runReq(n, w, h, $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nBad);
    $finish;
  end

endmodule
